// File: rtl/arb_pkg.sv
// Shared helpers for fixed-priority arbiter consumers: grant encoding and width helpers.
package arb_pkg;

   localparam int MAXN = 32;

   typedef struct packed {
      int   idx;
      logic multi;
   } enc_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Lowest set bit wins, matching the upstream fixed-priority order.
   function automatic enc_t onehot_lsb_idx(input logic [MAXN-1:0] vec);
      enc_t r;
      r.idx   = 0;
      r.multi = |(vec & (vec - MAXN'(1)));
      for (int i = MAXN - 1; i >= 0; i--)
         if (vec[i]) r.idx = i;
      return r;
   endfunction

endpackage

// File: rtl/grant_encoder.sv
// One-hot grant to index encoder with lowest-bit priority and multi-hot detect.
module grant_encoder
   import arb_pkg::*;
#(
   parameter int N    = 4,
   parameter int IDXW = idx_w(N)
) (
   input  logic [N-1:0]    grant,
   output logic [IDXW-1:0] idx,
   output logic            any,
   output logic            multi
);

   enc_t enc;

   always_comb begin
      enc   = onehot_lsb_idx(MAXN'(grant));
      idx   = IDXW'(enc.idx);
      multi = enc.multi;
      any   = |grant;
   end

endmodule

// File: rtl/grant_data_fifo.sv
// Captures the granted requester's payload plus its index into a small FIFO, acks the winner.
module grant_data_fifo
   import arb_pkg::*;
#(
   parameter int N     = 4,
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int IDXW  = idx_w(N),
   parameter int CNTW  = cnt_w(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    grant,
   input  logic [N*DW-1:0] req_data,
   output logic [N-1:0]    ack,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_data,
   output logic [IDXW-1:0] out_src,
   output logic [CNTW-1:0] count,
   output logic            full,
   output logic            onehot_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [IDXW-1:0] gidx;
   logic            gany;
   logic            gmulti;
   logic            push;
   logic            pop;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [DW-1:0]   mem_data [DEPTH];
   logic [IDXW-1:0] mem_src  [DEPTH];

   grant_encoder #(.N(N), .IDXW(IDXW)) u_enc (
      .grant (grant),
      .idx   (gidx),
      .any   (gany),
      .multi (gmulti)
   );

   assign out_valid = (count != '0);
   assign full      = (count == CNTW'(DEPTH));
   assign pop       = out_valid & out_ready;
   // A full FIFO still accepts a grant when the head leaves in the same cycle.
   assign push      = gany & (~full | pop);
   assign out_data  = mem_data[rd_ptr];
   assign out_src   = mem_src[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         ack        <= '0;
         onehot_err <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_src[i]  <= '0;
         end
      end else begin
         ack <= push ? (N'(1) << gidx) : '0;
         if (gany && gmulti) onehot_err <= 1'b1;
         if (push) begin
            mem_data[wr_ptr] <= req_data[int'(gidx)*DW +: DW];
            mem_src[wr_ptr]  <= gidx;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
